// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver_if
// Brief    : Pattern/control/display bundle for seg7_scan_driver.
//            Optional macro SEG7_DIM_EN adds the 2-bit bright control.
// Revision : 1.0 - initial release
// ============================================================================
interface seg7_scan_driver_if;
  logic [3:0][6:0] seg_in;
  logic            load;
  logic            enable;
`ifdef SEG7_DIM_EN
  logic [1:0]      bright;
`endif
  logic [6:0]      seg;
  logic [3:0]      an;
  logic            frame_done;

`ifdef SEG7_DIM_EN
  modport master (
    output seg_in, load, enable, bright,
    input  seg, an, frame_done
  );
  modport slave (
    input  seg_in, load, enable, bright,
    output seg, an, frame_done
  );
`else
  modport master (
    output seg_in, load, enable,
    input  seg, an, frame_done
  );
  modport slave (
    input  seg_in, load, enable,
    output seg, an, frame_done
  );
`endif
endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Brief    : Four-digit common-anode 7-segment scanner with dead-time blanking
//            and tear-free pattern commit. Macro SEG7_DIM_EN enables dimming.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  seg7_scan_driver_if.slave bus
);

  localparam int            c_cnt_w      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last   = c_cnt_w'(PRESCALE - 1);
  localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_CYCLES - 1);
  localparam logic [6:0]    c_seg_off    = 7'h7F;
  localparam logic [3:0]    c_an_off     = 4'hF;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic [1:0]           r_dig;
  logic [1:0]           w_dig_nxt;
  logic [3:0][6:0]      r_pend;
  logic [3:0][6:0]      r_shadow;
  logic [6:0]           r_seg;
  logic [6:0]           w_seg_nxt;
  logic [3:0]           r_an;
  logic [3:0]           w_an_nxt;
  logic                 r_frame_done;
  logic                 w_slot_end;
  logic                 w_frame_end;
  logic                 w_lit;

  assign w_slot_end  = (r_cnt == c_cnt_last);
  assign w_frame_end = w_slot_end && (r_dig == 2'd3);
  assign w_cnt_nxt   = w_slot_end ? '0 : r_cnt + 1'b1;
  assign w_dig_nxt   = w_slot_end ? r_dig + 2'd1 : r_dig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_dig   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dig   <= w_dig_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BLANK: if (r_cnt == c_blank_last) w_state_nxt = ST_SHOW;
      ST_SHOW:  if (w_slot_end)            w_state_nxt = ST_BLANK;
      default:                             w_state_nxt = ST_BLANK;
    endcase
  end

  // A load coinciding with the boundary lands in pend while shadow takes the
  // previous pend, so the new set surfaces one frame later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend   <= {4{c_seg_off}};
      r_shadow <= {4{c_seg_off}};
    end else begin
      if (bus.load)    r_pend   <= bus.seg_in;
      if (w_frame_end) r_shadow <= r_pend;
    end
  end

`ifdef SEG7_DIM_EN
  localparam int                 c_on_w  = c_cnt_w + 1;
  localparam logic [c_on_w-1:0]  c_blank = c_on_w'(BLANK_CYCLES);

  logic [1:0]        r_bright;
  logic [c_on_w-1:0] w_on_time [4];
  logic [c_on_w-1:0] w_show_idx;

  for (genvar b = 0; b < 4; b++) begin : g_on_time
    localparam int c_on = ((b + 1) * (PRESCALE - BLANK_CYCLES)) >> 2;
    assign w_on_time[b] = c_on_w'(c_on);
  end

  // Level is latched at slot start so the on-time is stable for the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bright <= 2'd3;
    end else if (r_cnt == '0) begin
      r_bright <= bus.bright;
    end
  end

  assign w_show_idx = {1'b0, r_cnt} - c_blank;
  assign w_lit      = (r_state == ST_SHOW) && (w_show_idx < w_on_time[r_bright]);
`else
  assign w_lit      = (r_state == ST_SHOW);
`endif

  always_comb begin
    w_an_nxt  = c_an_off;
    w_seg_nxt = c_seg_off;
    if (bus.enable && w_lit) begin
      w_an_nxt  = ~(4'b0001 << r_dig);
      w_seg_nxt = r_shadow[r_dig];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an         <= c_an_off;
      r_seg        <= c_seg_off;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_frame_done <= w_frame_end;
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for the four-digit common-anode seven-segment display. It sits directly downstream of the operating-mode display encoders, which present four active-low 7-bit digit patterns. The block captures a pattern set on a load strobe and commits it tear-free at frame boundaries. It then scans the digits one at a time with a dead-time blank between slots to suppress ghosting, and drives the shared segment bus and the per-digit anode lines.

## Interface
- `PRESCALE`, default 50000: clock cycles per digit slot; 1 kHz per digit at 50 MHz. Must be > `BLANK_CYCLES`.
- `BLANK_CYCLES`, default 16: cycles at the start of each slot during which all anodes are off. Must be ≥ 1.
- `clk`  in  1: single system clock; everything is synchronous to the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `seg_in`  in  [6:0] x [3:0]: active-low segment patterns; `seg_in[i]` drives digit i, digit 3 is leftmost.
- `load`  in  1: when high on a rising edge, `seg_in` is captured into the pending register.
- `enable`  in  1: low forces the display dark; scanning continues.
- `bright`  in  2: brightness level 0..3. Present only with `SEG7_DIM_EN`.
- `seg`  out  7: active-low segment bus, {g,f,e,d,c,b,a}.
- `an`  out  4: active-low anode select; `an[i]`=0 lights digit i.
- `frame_done`  out  1: one-cycle pulse when the digit-3 slot ends.

## Operation
- Registers:
  - `pend[3:0]`: written on `load`.
  - `shadow[3:0]`: the displayed set.
  - Slot counter `cnt`, width $clog2(PRESCALE), range 0..PRESCALE-1.
  - Digit index `dig`, 2 bits.
  - Phase FSM.
- FSM states and transitions:
  - BLANK: `cnt` < BLANK_CYCLES. `an`=4'hF, `seg`=7'h7F.
  - SHOW: `cnt` ≥ BLANK_CYCLES. `an` = one-hot-low on `dig`, `seg` = `shadow[dig]`.
  - BLANK→SHOW when `cnt` = BLANK_CYCLES-1.
  - SHOW→BLANK when `cnt` = PRESCALE-1. At that point `cnt`←0 and `dig`←`dig`+1; wrap 3→0.
- Scan order is 0,1,2,3,0,…
- Frame boundary is the cycle in which `cnt`=PRESCALE-1 and `dig`=3. In that cycle:
  - `shadow`←`pend`.
  - `frame_done` is asserted on the next registered output.
- `load` during the boundary cycle: `shadow` takes the old `pend`; the new value appears one frame later.
- `load` at any other time: it never alters `shadow` mid-frame.
- `enable`=0: output registers load `an`=4'hF and `seg`=7'h7F. `cnt`, `dig`, `pend`, `shadow` and `frame_done` are unaffected.
- Reset (async, any time including mid-slot) sets:
  - `cnt`=0, `dig`=0, FSM=BLANK.
  - `pend` and `shadow` all 7'h7F.
  - `an`=4'hF, `seg`=7'h7F, `frame_done`=0.

## Timing
- `an`, `seg` and `frame_done` are registered and change together on one edge, one cycle after the internal state that produces them.
- After `rst` deasserts, digit 0 first lights on edge BLANK_CYCLES+1. With reset patterns it shows blank (7'h7F).
- Each slot is exactly PRESCALE cycles: BLANK_CYCLES dark, then PRESCALE-BLANK_CYCLES lit. A frame is 4·PRESCALE cycles.
- Load-to-visible latency is from the `load` edge to the digit-0 lit phase of the first frame whose boundary follows the load. Maximum ≈ 4·PRESCALE + BLANK_CYCLES + 1 cycles.
- `frame_done` pulses once every 4·PRESCALE cycles, one cycle wide.
- The anodes of two digits are never low in the same cycle. A SHOW→SHOW digit change never occurs without ≥ BLANK_CYCLES dark cycles between.

## Configuration
- `SEG7_DIM_EN` defined:
  - The `bright` port exists and is sampled at each slot start (`cnt`=0).
  - Within SHOW, the digit is lit only for the first ((bright+1)·(PRESCALE-BLANK_CYCLES))>>2 cycles. For the remainder of the slot, `an`=4'hF and `seg`=7'h7F.
  - `bright`=3 gives full on-time.
  - A computed on-time of 0 means the digit stays dark for the whole slot.
- `SEG7_DIM_EN` undefined:
  - No `bright` port.
  - The SHOW phase is lit for its full length.

## Test plan
Bench parameters are PRESCALE=8, BLANK_CYCLES=2.
- Reset then release with no load -> `an`=F, `seg`=7F throughout. `frame_done` pulses every 32 cycles, the first 32 cycles after release.
- Load {3:7'h40, 2:7'h79, 1:7'h24, 0:7'h30} just after a boundary -> the next frame shows digit 0 as 7'h30 with `an`=4'b1110 for 6 cycles, then 2 dark cycles. Digit 1 then shows 7'h24 with `an`=4'b1101, and so on through digit 3.
- Load asserted exactly in the boundary cycle -> the next frame shows the previous set and the following frame shows the new set.
- Drop `enable` mid-SHOW for 5 cycles -> dark from the next edge. On re-enable, scanning continues at the same `dig`/`cnt` phase.
- Assert `rst` mid-slot on digit 2 -> `an`=F and `seg`=7F immediately (async). After release, the scan restarts at digit 0 and patterns are blank.
- With `SEG7_DIM_EN`, `bright`=1 -> each digit is lit 3 cycles per slot and dark 5. With `bright`=0 -> lit 1 cycle.
